im2col_row_streamer: RTL and testbench

- Producer side of the convolution datapath. Accepts a raster-order 8-bit pixel stream of one IMG_H x IMG_W frame and buffers it in a rotating line buffer.
- For each output row, emits all OUT_W 3x3 windows in one beat, im2col-packed. This is exactly one row's worth of col_data for the 26-lane PE row.
- Sits between the pixel source/DMA and the convolution accelerator. Replaces a fully materialised 9*26*26 col_data array.

---
 rtl/im2col_row_streamer.sv | 180 ++++++++++++++++++
 tb/tb_im2col_row_streamer.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/im2col_row_streamer.sv
`default_nettype none
//============================================================================
// Module  : im2col_row_streamer
// Desc    : Rotating 3-row line buffer that emits one im2col-packed output row
//           (all OUT_W 3x3 windows) per beat. Define IM2COL_SKID_EN for a
//           4-slot buffer that keeps accepting pixels while a row is pending.
// Rev     : 1.0
//============================================================================
module im2col_row_streamer #(
    parameter int IMG_W = 28,
    parameter int IMG_H = 28,
    parameter int DW    = 8,
    parameter int OUT_W = IMG_W - 2,
    parameter int OUT_H = IMG_H - 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  pix_valid,
    output logic                  pix_ready,
    input  logic [DW-1:0]         pix_data,
    output logic                  row_valid,
    input  logic                  row_ready,
    output logic [9*OUT_W*DW-1:0] row_data,
    output logic [4:0]            row_idx,
    output logic                  row_last,
    output logic                  frame_done
);

`ifdef IM2COL_SKID_EN
    localparam int NSLOT   = 4;
    localparam bit SKID_EN = 1'b1;
`else
    localparam int NSLOT   = 3;
    localparam bit SKID_EN = 1'b0;
`endif

    localparam int          CW       = $clog2(IMG_W);
    localparam int          RW       = $clog2(IMG_H);
    localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
    localparam logic [RW-1:0] LAST_IN  = RW'(IMG_H - 1);
    localparam logic [4:0]  LAST_ROW = 5'(OUT_H - 1);

    typedef enum logic [1:0] {
        S_FILL = 2'd0,
        S_EMIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [CW-1:0]   r_col_cnt;
    logic [RW-1:0]   r_in_row;
    logic [1:0]      r_wr_slot;
    logic [1:0]      r_base;
    logic [4:0]      r_out_row;
    logic            r_in_done;
    logic            r_pend;
    logic            r_run;
    logic [DW-1:0]   r_lb [NSLOT][IMG_W];

    logic            w_pix_xfer;
    logic            w_row_end;
    logic            w_emit_req;
    logic            w_row_xfer;
    logic            w_emitting;

    function automatic logic [1:0] slot_add(input logic [1:0] s, input logic [1:0] k);
        logic [2:0] t;
        t = {1'b0, s} + {1'b0, k};
        if (t >= 3'(NSLOT)) t = t - 3'(NSLOT);
        return t[1:0];
    endfunction

    // A row completing while one is still pending (skid mode) blocks input until it drains
    assign pix_ready  = r_run && !r_in_done &&
                        ((r_state == S_FILL) || (SKID_EN && (r_state == S_EMIT) && !r_pend));
    assign w_pix_xfer = pix_valid && pix_ready;
    assign w_row_end  = w_pix_xfer && (r_col_cnt == LAST_COL);
    assign w_emit_req = w_row_end && (r_in_row >= RW'(2));
    assign w_emitting = (r_state == S_EMIT);
    assign w_row_xfer = w_emitting && row_ready;
    assign row_idx    = r_out_row;
    assign row_last   = w_emitting && (r_out_row == LAST_ROW);

    always_comb begin
        w_state_nxt = r_state;
        row_valid   = 1'b0;
        frame_done  = 1'b0;
        case (r_state)
            S_FILL: begin
                if (w_emit_req) w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                row_valid = 1'b1;
                if (w_row_xfer) begin
                    if (r_out_row == LAST_ROW)    w_state_nxt = S_DONE;
                    else if (r_pend || w_emit_req) w_state_nxt = S_EMIT;
                    else                          w_state_nxt = S_FILL;
                end
            end
            S_DONE: begin
                frame_done  = 1'b1;
                w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_FILL;
            r_col_cnt <= '0;
            r_in_row  <= '0;
            r_wr_slot <= '0;
            r_base    <= '0;
            r_out_row <= '0;
            r_in_done <= 1'b0;
            r_pend    <= 1'b0;
            r_run     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= 1'b1;
            if (r_state == S_DONE) begin
                r_col_cnt <= '0;
                r_in_row  <= '0;
                r_wr_slot <= '0;
                r_base    <= '0;
                r_out_row <= '0;
                r_in_done <= 1'b0;
                r_pend    <= 1'b0;
            end else begin
                if (w_pix_xfer) begin
                    if (w_row_end) begin
                        r_col_cnt <= '0;
                        r_wr_slot <= slot_add(r_wr_slot, 2'd1);
                        if (r_in_row == LAST_IN) begin
                            r_in_row  <= '0;
                            r_in_done <= 1'b1;
                        end else begin
                            r_in_row <= r_in_row + 1'b1;
                        end
                    end else begin
                        r_col_cnt <= r_col_cnt + 1'b1;
                    end
                end
                // r_base tracks the slot holding input row out_row
                if (w_row_xfer) begin
                    r_out_row <= r_out_row + 5'd1;
                    r_base    <= slot_add(r_base, 2'd1);
                    r_pend    <= 1'b0;
                end else if (w_emitting && w_emit_req) begin
                    r_pend <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int s = 0; s < NSLOT; s++)
                for (int c = 0; c < IMG_W; c++)
                    r_lb[s][c] <= '0;
        end else if (w_pix_xfer) begin
            r_lb[r_wr_slot][r_col_cnt] <= pix_data;
        end
    end

    for (genvar kr = 0; kr < 3; kr++) begin : g_kr
        logic [1:0] w_rd_slot;
        assign w_rd_slot = slot_add(r_base, 2'(kr));
        for (genvar i = 0; i < OUT_W; i++) begin : g_win
            for (genvar kc = 0; kc < 3; kc++) begin : g_kc
                assign row_data[(i*9 + kr*3 + kc)*DW +: DW] =
                    w_emitting ? r_lb[w_rd_slot][i + kc] : '0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_im2col_row_streamer.sv
`default_nettype none
//============================================================================
// Module  : tb_im2col_row_streamer
// Desc    : Directed self-checking bench with a frame-level window model.
// Rev     : 1.0
//============================================================================
module tb_im2col_row_streamer;
    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int DW    = 8;
    localparam int OUT_W = 26;
    localparam int OUT_H = 26;
    localparam int RDW   = 9*OUT_W*DW;
    localparam int NPIX  = IMG_W*IMG_H;
`ifdef IM2COL_SKID_EN
    localparam int EXP_SPAN = 784;
    localparam int PART_ACC = 100;
`else
    localparam int EXP_SPAN = 809;
    localparam int PART_ACC = 84;
`endif

    logic           clk = 1'b0;
    logic           reset = 1'b1;
    logic           pix_valid = 1'b0;
    logic           pix_ready;
    logic [DW-1:0]  pix_data = '0;
    logic           row_valid;
    logic           row_ready = 1'b1;
    logic [RDW-1:0] row_data;
    logic [4:0]     row_idx;
    logic           row_last;
    logic           frame_done;

    im2col_row_streamer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .DW(DW)) dut (
        .clk(clk), .reset(reset),
        .pix_valid(pix_valid), .pix_ready(pix_ready), .pix_data(pix_data),
        .row_valid(row_valid), .row_ready(row_ready), .row_data(row_data),
        .row_idx(row_idx), .row_last(row_last), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_data(input string name, input logic [RDW-1:0] act, input logic [RDW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            for (int e = 0; e < 9*OUT_W; e++) begin
                if (act[e*DW +: DW] !== exp[e*DW +: DW]) begin
                    $display("FAIL %s: element %0d got %0d expected %0d", name, e, act[e*DW +: DW], exp[e*DW +: DW]);
                    break;
                end
            end
        end
    endtask

    task automatic finish_run();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out at cycle %0d", name, cyc);
        finish_run();
    endtask

    // Window i, element kr*3+kc of output row r is frame pixel (r+kr, i+kc)
    function automatic logic [RDW-1:0] model_row(input int off, input int r);
        logic [RDW-1:0] v;
        v = '0;
        for (int i = 0; i < OUT_W; i++)
            for (int kr = 0; kr < 3; kr++)
                for (int kc = 0; kc < 3; kc++)
                    v[(i*9 + kr*3 + kc)*DW +: DW] = 8'(((r + kr)*IMG_W + i + kc + off) % 256);
        return v;
    endfunction

    // ---------------- scoreboard / compare process ----------------
    int             off_q[$];
    int             exp_idx = 0;
    int             rows_seen = 0;
    int             last_cnt = 0;
    int             done_cnt = 0;
    int             stall_checks = 0;
    int             last_hs_cyc = -10;
    logic           prev_stall = 1'b0;
    logic [RDW-1:0] prev_data = '0;
    logic [4:0]     prev_idx = '0;
    logic [71:0]    w0_lit;
    logic [71:0]    w25_lit;

    initial begin
        w0_lit  = {8'd58, 8'd57, 8'd56, 8'd30, 8'd29, 8'd28, 8'd2, 8'd1, 8'd0};
        w25_lit = {8'd15, 8'd14, 8'd13, 8'd243, 8'd242, 8'd241, 8'd215, 8'd214, 8'd213};
    end

    always @(negedge clk) begin
        if (reset) begin
            exp_idx    = 0;
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                stall_checks++;
                check("stall_valid", row_valid, 1);
                check("stall_idx", row_idx, prev_idx);
                check_data("stall_data", row_data, prev_data);
            end
`ifndef IM2COL_SKID_EN
            if (row_valid && !row_ready) check("stall_pix_ready", pix_ready, 0);
`endif
            if (row_valid && row_ready) begin
                if (off_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_row: got row_idx %0d expected no row", row_idx);
                end else begin
                    check("row_idx", row_idx, exp_idx);
                    check("row_last", row_last, exp_idx == OUT_H-1);
                    check_data("row_data", row_data, model_row(off_q[0], exp_idx));
                    if (off_q[0] == 0 && exp_idx == 0)
                        check("row0_win0_literal", row_data[0 +: 72], w0_lit);
                    if (off_q[0] == 0 && exp_idx == OUT_H-1)
                        check("row25_win25_literal", row_data[25*72 +: 72], w25_lit);
                    rows_seen++;
                    if (row_last) last_cnt++;
                    if (exp_idx == OUT_H-1) begin
                        exp_idx = 0;
                        void'(off_q.pop_front());
                        last_hs_cyc = cyc;
                    end else begin
                        exp_idx++;
                    end
                end
            end
            if (frame_done) begin
                done_cnt++;
                check("frame_done_timing", cyc, last_hs_cyc + 1);
            end
            prev_stall = row_valid && !row_ready;
            prev_data  = row_data;
            prev_idx   = row_idx;
        end
    end

    // ---------------- row_ready driver (with optional stall) ----------------
    logic main_ready = 1'b1;
    int   stall_row  = -1;
    int   stall_left = 0;

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (stall_row >= 0 && row_valid && int'(row_idx) == stall_row && stall_left > 0) begin
                row_ready = 1'b0;
                stall_left--;
            end else begin
                row_ready = main_ready;
            end
        end
    end

    // ---------------- pixel driver ----------------
    int first_acc = 0;
    int last_acc  = 0;
    int n_acc     = 0;

    task automatic send_frame(input int off, input bit gaps);
        off_q.push_back(off);
        for (int p = 0; p < NPIX; p++) begin
            int  budget;
            bit  got;
            budget   = 0;
            got      = 1'b0;
            pix_data = 8'((p + off) % 256);
            while (!got) begin
                pix_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                if (pix_valid && pix_ready) begin
                    got = 1'b1;
                    n_acc++;
                    if (n_acc == 1) first_acc = cyc;
                    last_acc = cyc;
                end else begin
                    budget++;
                    if (budget > 300) timeout("pixel_accept");
                end
                @(posedge clk);
                #1;
            end
        end
        pix_valid = 1'b0;
    endtask

    task automatic send_partial(input int npix, output int acc);
        acc = 0;
        for (int t = 0; t < 150 && acc < npix; t++) begin
            pix_valid = 1'b1;
            pix_data  = 8'(acc % 256);
            @(negedge clk);
            if (pix_ready) acc++;
            @(posedge clk);
            #1;
        end
        pix_valid = 1'b0;
    endtask

    task automatic wait_done(input int target);
        int b;
        b = 0;
        while (done_cnt < target) begin
            @(posedge clk);
            b++;
            if (b > 400) timeout("frame_done_wait");
        end
        repeat (5) @(posedge clk);
        #1;
        check("frame_done_count", done_cnt, target);
    endtask

    int rows0;
    int last0;
    int stall0;
    int acc;

    initial begin
        // reset state
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        check("reset_pix_ready", pix_ready, 0);
        check("reset_row_valid", row_valid, 0);
        check("reset_row_last", row_last, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_row_idx", row_idx, 0);
        check_data("reset_row_data", row_data, '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        check("pix_ready_before_release_edge", pix_ready, 0);
        @(negedge clk);
        check("pix_ready_after_reset", pix_ready, 1);
        @(posedge clk);
        #1;

        // full frame, no gaps
        rows0 = rows_seen; last0 = last_cnt; n_acc = 0;
        send_frame(0, 1'b0);
        check("accept_span", last_acc - first_acc + 1, EXP_SPAN);
        wait_done(1);
        check("frame1_rows", rows_seen - rows0, 26);
        check("frame1_row_last", last_cnt - last0, 1);

        // consumer stall on row 3
        rows0 = rows_seen; stall0 = stall_checks;
        stall_row = 3; stall_left = 10;
        send_frame(0, 1'b0);
        wait_done(2);
        stall_row = -1;
        check("stall_cycles", stall_checks - stall0, 10);
        check("stall_frame_rows", rows_seen - rows0, 26);

        // random valid gaps
        rows0 = rows_seen;
        send_frame(0, 1'b1);
        wait_done(3);
        check("gap_frame_rows", rows_seen - rows0, 26);

        // reset in the middle of a frame with a row pending
        rows0 = rows_seen;
        main_ready = 1'b0;
        @(posedge clk);
        #1;
        send_partial(100, acc);
        check("partial_accepted", acc, PART_ACC);
        @(negedge clk);
        check("partial_row_pending", row_valid, 1);
        @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        check("midreset_pix_ready", pix_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("midreset_row_valid", row_valid, 0);
        check("partial_no_rows", rows_seen - rows0, 0);
        @(posedge clk);
        #1;
        main_ready = 1'b1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        rows0 = rows_seen;
        send_frame(0, 1'b0);
        wait_done(4);
        check("post_reset_rows", rows_seen - rows0, 26);

        // two back-to-back frames with distinct content
        rows0 = rows_seen; last0 = last_cnt;
        send_frame(0, 1'b0);
        send_frame(100, 1'b0);
        wait_done(6);
        check("b2b_rows", rows_seen - rows0, 52);
        check("b2b_row_last", last_cnt - last0, 2);
        check("scoreboard_drained", off_q.size(), 0);

        finish_run();
    end

    initial begin
        #2000000;
        timeout("global");
    end

endmodule
`default_nettype wire
